// File: rtl/sccb_arb_pkg.sv
// Shared encodings for the SCCB two-port arbiter.
// Command, response and FSM state values used by the top and the bench.
package sccb_arb_pkg;

    localparam logic [2:0] CMD_IDLE = 3'b000;
    localparam logic [2:0] CMD_WR   = 3'b001;
    localparam logic [2:0] CMD_RD   = 3'b010;

    localparam logic [1:0] RESP_NULL = 2'b00;
    localparam logic [1:0] RESP_DVA  = 2'b01;
    localparam logic [1:0] RESP_ERR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_req(input logic [2:0] cmd);
        return (cmd == CMD_WR) || (cmd == CMD_RD);
    endfunction

endpackage

// File: rtl/sccb_rr_arb.sv
// Two-way request-to-grant logic for the SCCB arbiter.
// Fixed priority favours port 0; otherwise the non-last-owner wins a tie.
module sccb_rr_arb (
    input  logic req0_i,
    input  logic req1_i,
    input  logic fixed_prio_i,
    input  logic last_owner_i,
    output logic gnt_valid_o,
    output logic gnt_port_o
);

    // Resolve a single winner from the current requests
    always_comb begin
        gnt_valid_o = req0_i | req1_i;
        gnt_port_o  = 1'b0;
        if (req0_i && req1_i) begin
            gnt_port_o = fixed_prio_i ? 1'b0 : ~last_owner_i;
        end else if (req1_i) begin
            gnt_port_o = 1'b1;
        end
    end

endmodule

// File: rtl/sccb_arbiter.sv
// Shares one SCCB master between the init sequencer and the debug path.
// One whole transaction per grant, with a timeout that returns ERR.
module sccb_arbiter
    import sccb_arb_pkg::*;
#(
    parameter bit          FIXED_PRIO     = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned TO_W           = 16,
    parameter logic [7:0]  DEFAULT_DIV    = 8'd50
) (
    input  logic        config_clk,
    input  logic        config_reset_n,
    input  logic [2:0]  m0_mcmd,
    input  logic [14:0] m0_maddr,
    input  logic [7:0]  m0_mdata,
    input  logic [7:0]  m0_div,
    output logic        m0_scmdaccept,
    output logic [1:0]  m0_sresp,
    output logic [7:0]  m0_sdata,
    input  logic [2:0]  m1_mcmd,
    input  logic [14:0] m1_maddr,
    input  logic [7:0]  m1_mdata,
    input  logic [7:0]  m1_div,
    output logic        m1_scmdaccept,
    output logic [1:0]  m1_sresp,
    output logic [7:0]  m1_sdata,
    output logic [2:0]  s_mcmd,
    output logic [14:0] s_maddr,
    output logic [7:0]  s_mdata,
    output logic [7:0]  s_sccb_div,
    input  logic        s_scmdaccept,
    input  logic [1:0]  s_sresp,
    input  logic [7:0]  s_sdata,
    output logic        owner,
    output logic        busy
);

    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_W-1:0] TO_LAST =
        TO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic [2:0]        mcmd_q, mcmd_d;
    logic [14:0]       maddr_q, maddr_d;
    logic [7:0]        mdata_q, mdata_d;
    logic [7:0]        div_q, div_d;

    logic gnt_valid;
    logic gnt_port;
    logic dva;
    logic timeout;
    logic acc_fwd;
    logic [1:0] resp_fwd;

    sccb_rr_arb u_arb (
        .req0_i       (is_req(m0_mcmd)),
        .req1_i       (is_req(m1_mcmd)),
        .fixed_prio_i (FIXED_PRIO),
        .last_owner_i (owner_q),
        .gnt_valid_o  (gnt_valid),
        .gnt_port_o   (gnt_port)
    );

    assign dva     = (s_sresp == RESP_DVA);
    assign timeout = TO_EN && (cnt_q == TO_LAST);

    // State, timeout counter and captured command registers
    always_ff @(posedge config_clk or negedge config_reset_n) begin
        if (!config_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= 1'b1;
            mcmd_q  <= CMD_IDLE;
            maddr_q <= '0;
            mdata_q <= '0;
            div_q   <= DEFAULT_DIV;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            mcmd_q  <= mcmd_d;
            maddr_q <= maddr_d;
            mdata_q <= mdata_d;
            div_q   <= div_d;
        end
    end

    // Next state: grant and capture in IDLE, end on DVA or timeout
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        mcmd_d  = mcmd_q;
        maddr_d = maddr_q;
        mdata_d = mdata_q;
        div_d   = div_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d = CMD;
                    cnt_d   = '0;
                    owner_d = gnt_port;
                    mcmd_d  = gnt_port ? m1_mcmd  : m0_mcmd;
                    maddr_d = gnt_port ? m1_maddr : m0_maddr;
                    mdata_d = gnt_port ? m1_mdata : m0_mdata;
                    div_d   = gnt_port ? m1_div   : m0_div;
                end
            end
            CMD: begin
                cnt_d = cnt_q + TO_W'(1);
                if (s_scmdaccept && dva) begin
                    state_d = IDLE;
                    mcmd_d  = CMD_IDLE;
                end else if (timeout) begin
                    state_d = IDLE;
                    mcmd_d  = CMD_IDLE;
                end else if (s_scmdaccept) begin
                    state_d = RESP;
                    mcmd_d  = CMD_IDLE;
                end
            end
            RESP: begin
                cnt_d = cnt_q + TO_W'(1);
                if (dva || timeout) begin
                    state_d = IDLE;
                    mcmd_d  = CMD_IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Route accept and response to the owner only; ERR on timeout
    always_comb begin
        acc_fwd  = 1'b0;
        resp_fwd = RESP_NULL;
        if (state_q == CMD) begin
            acc_fwd = s_scmdaccept;
        end
        if (state_q != IDLE) begin
            resp_fwd = (timeout && !dva) ? RESP_ERR : s_sresp;
        end
        m0_scmdaccept = acc_fwd & ~owner_q;
        m1_scmdaccept = acc_fwd &  owner_q;
        m0_sresp      = owner_q ? RESP_NULL : resp_fwd;
        m1_sresp      = owner_q ? resp_fwd  : RESP_NULL;
    end

    assign m0_sdata   = s_sdata;
    assign m1_sdata   = s_sdata;
    assign s_mcmd     = mcmd_q;
    assign s_maddr    = maddr_q;
    assign s_mdata    = mdata_q;
    assign s_sccb_div = div_q;
    assign owner      = owner_q;
    assign busy       = (state_q != IDLE);

endmodule
